screen_mem_arbiter: RTL

- Shares the single-port 8K x 16 Hack screen RAM between two requesters.
- Requester 1 is the VGA pixel fetch path, which feeds the image generator through the address/data word interface.
- Requester 2 is the Hack CPU memory-mapped screen access (reads and writes).
- VGA has default priority. CPU aging guarantees forward progress, and a sticky flag reports any VGA fetch deadline miss.

---
 rtl/screen_mem_arbiter_pkg.sv | 28 ++
 rtl/screen_mem_arbiter_sat_wait_counter.sv | 30 +++
 rtl/screen_mem_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/screen_mem_arbiter_pkg.sv
// Shared constants and types for the Hack screen RAM arbiter.
package screen_mem_arbiter_pkg;

   // Default geometry of the 8K x 16 Hack screen memory.
   localparam int SCREEN_ADDR_W = 13;
   localparam int SCREEN_DATA_W = 16;

   // Owner of the access issued in the previous cycle.
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_VGA  = 2'd1;
   localparam logic [1:0] OWN_CPU  = 2'd2;

   // Priority FSM states.
   localparam logic PRIO_VGA = 1'b0;
   localparam logic PRIO_CPU = 1'b1;

   // Response stage: who owns the RAM read data next cycle, and whether it was a read.
   typedef struct packed {
      logic [1:0] owner;
      logic       is_read;
   } resp_t;

   // Bits needed to hold a counter value in 0..max.
   function automatic int cnt_width(input int max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/screen_mem_arbiter_sat_wait_counter.sv
// Counts consecutive cycles a requester is pending without a grant, saturating at MAX.
module sat_wait_counter
   import screen_mem_arbiter_pkg::*;
#(
   parameter  int MAX = 8,
   localparam int CW  = cnt_width(MAX)
)(
   input  logic          pixel_clock,
   input  logic          reset,
   input  logic          pending,
   input  logic          granted,
   output logic [CW-1:0] count,
   output logic          at_max
);

   // Wait counter: clears on grant or when the request drops, otherwise counts up to MAX.
   always_ff @(posedge pixel_clock) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values; blocking here would race other always_ff blocks.
      if (reset) begin
         count <= '0;
      end else if (!pending || granted) begin
         count <= '0;
      end else if (count != CW'(MAX)) begin
         count <= count + 1'b1;
      end
   end

   assign at_max = (count == CW'(MAX));

endmodule

// File: rtl/screen_mem_arbiter.sv
// Arbitrates the single-port Hack screen RAM between the VGA fetch path and the CPU.
// VGA has default priority; CPU aging forces a CPU slot after CPU_MAX_WAIT losses.
module screen_mem_arbiter
   import screen_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = SCREEN_ADDR_W,
   parameter int DATA_W       = SCREEN_DATA_W,
   parameter int CPU_MAX_WAIT = 8,
   parameter int VGA_DEADLINE = 4
)(
   input  logic              pixel_clock,
   input  logic              reset,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic [DATA_W-1:0] vga_rdata,
   output logic              vga_rvalid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              vga_miss,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int CPU_CW = cnt_width(CPU_MAX_WAIT);
   localparam int VGA_CW = cnt_width(VGA_DEADLINE);

   logic              r_prio;
   resp_t             r_resp;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_vga_rdata;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic              r_vga_miss;

   logic              w_vga_win;
   logic              w_cpu_win;
   logic              w_cpu_age;
   logic              w_vga_hit;
   logic              w_cpu_load;
   logic              w_cpu_at_max;
   logic              w_vga_at_max;
   logic [CPU_CW-1:0] w_cpu_wait;
   logic [VGA_CW-1:0] w_vga_wait;

   sat_wait_counter #(.MAX(CPU_MAX_WAIT)) u_cpu_wait (
      .pixel_clock (pixel_clock),
      .reset       (reset),
      .pending     (cpu_req),
      .granted     (w_cpu_win),
      .count       (w_cpu_wait),
      .at_max      (w_cpu_at_max)
   );

   sat_wait_counter #(.MAX(VGA_DEADLINE)) u_vga_wait (
      .pixel_clock (pixel_clock),
      .reset       (reset),
      .pending     (vga_req),
      .granted     (w_vga_win),
      .count       (w_vga_wait),
      .at_max      (w_vga_at_max)
   );

   // Slot winner for this cycle; no grant at all while in reset.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; a missed branch would infer a latch.
      w_vga_win = 1'b0;
      w_cpu_win = 1'b0;
      if (!reset) begin
         if (r_prio == PRIO_CPU) begin
            w_cpu_win = cpu_req;
            w_vga_win = vga_req & ~cpu_req;
         end else begin
            w_vga_win = vga_req;
            w_cpu_win = cpu_req & ~vga_req;
         end
      end
   end

   assign vga_gnt = w_vga_win;
   assign cpu_gnt = w_cpu_win;

   // RAM request mux; an idle slot re-presents the last address and never writes.
   always_comb begin
      ram_addr  = r_ram_addr;
      ram_we    = 1'b0;
      ram_wdata = '0;
      if (reset) begin
         ram_addr = '0;
      end else if (w_vga_win) begin
         ram_addr = vga_addr;
      end else if (w_cpu_win) begin
         ram_addr = cpu_addr;
         ram_we   = cpu_we;
         if (cpu_we) begin
            ram_wdata = cpu_wdata;
         end
      end
   end

   // The counter hits its threshold at this edge, so the effect lands next cycle, never this one.
   assign w_cpu_age = cpu_req & ~w_cpu_win &
                      (w_cpu_at_max | (w_cpu_wait == CPU_CW'(CPU_MAX_WAIT - 1)));
   assign w_vga_hit = w_vga_at_max |
                      (vga_req & ~w_vga_win & (w_vga_wait == VGA_CW'(VGA_DEADLINE - 1)));

   // Priority FSM: age into PRIO_CPU, drop back once the CPU has had its slot.
   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         r_prio <= PRIO_VGA;
      end else begin
         case (r_prio)
            PRIO_VGA: if (w_cpu_age) r_prio <= PRIO_CPU;
            PRIO_CPU: if (w_cpu_win) r_prio <= PRIO_VGA;
            default:  r_prio <= PRIO_VGA;
         endcase
      end
   end

   // Response stage and idle-address hold, captured at grant time.
   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         r_resp     <= '{owner: OWN_NONE, is_read: 1'b0};
         r_ram_addr <= '0;
      end else begin
         r_ram_addr <= ram_addr;
         if (w_vga_win) begin
            r_resp <= '{owner: OWN_VGA, is_read: 1'b1};
         end else if (w_cpu_win) begin
            r_resp <= '{owner: OWN_CPU, is_read: ~cpu_we};
         end else begin
            r_resp <= '{owner: OWN_NONE, is_read: 1'b0};
         end
      end
   end

   assign vga_rvalid = ~reset & (r_resp.owner == OWN_VGA);
   assign cpu_ack    = ~reset & (r_resp.owner == OWN_CPU);
   assign w_cpu_load = cpu_ack & r_resp.is_read;
   assign vga_rdata  = reset ? '0 : (vga_rvalid ? ram_rdata : r_vga_rdata);
   assign cpu_rdata  = reset ? '0 : (w_cpu_load ? ram_rdata : r_cpu_rdata);

   // Read-data hold registers and the sticky deadline-miss flag.
   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         r_vga_rdata <= '0;
         r_cpu_rdata <= '0;
         r_vga_miss  <= 1'b0;
      end else begin
         r_vga_rdata <= vga_rdata;
         r_cpu_rdata <= cpu_rdata;
         r_vga_miss  <= r_vga_miss | w_vga_hit;
      end
   end

   assign vga_miss = r_vga_miss;

endmodule
